// File: rtl/tl_intersection_sched.sv
// Two-direction (NS/EW) intersection phase scheduler with a programmable dwell register bank.
// Optional emergency all-red override is enabled by defining TL_EMERGENCY_EN.
module tl_intersection_sched #(
  parameter int unsigned GREEN_RST  = 5,
  parameter int unsigned YELLOW_RST = 2,
  parameter int unsigned ALLRED_RST = 1
) (
  input  logic       clk,
  input  logic       reset_b,
  input  logic       start,
  input  logic       cs,
  input  logic       write,
  input  logic [1:0] addr,
  input  logic [3:0] wr_data,
  output logic [3:0] rd_data,
  input  logic       ns_req,
  input  logic       ew_req,
`ifdef TL_EMERGENCY_EN
  input  logic       emerg,
`endif
  output logic       ns_red,
  output logic       ns_yellow,
  output logic       ns_green,
  output logic       ew_red,
  output logic       ew_yellow,
  output logic       ew_green,
  output logic       busy
);

  localparam int unsigned DW = 4;
  localparam int unsigned SW = 3;

  typedef enum logic [SW-1:0] {
    IDLE      = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    ALLRED_A  = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5,
    ALLRED_B  = 3'd6
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] timer_q, timer_d;
  logic [DW-1:0] green_q, yellow_q, allred_q;
  logic [DW-1:0] rd_data_q, rd_mux;
  logic          expired;
  logic          emerg_w;
  logic          status_b3;

`ifdef TL_EMERGENCY_EN
  assign emerg_w   = emerg;
  assign status_b3 = emerg;
`else
  assign emerg_w   = 1'b0;
  assign status_b3 = busy;
`endif

  // A dwell of 0 behaves as 1 cycle, so the timer load saturates at 0.
  function automatic logic [DW-1:0] load_val(input logic [DW-1:0] r);
    return (r == '0) ? '0 : DW'(r - DW'(1));
  endfunction

  assign expired = (timer_q == '0);
  assign busy    = (state_q != IDLE);
  assign rd_data = rd_data_q;

  // Next-state and dwell timer
  always_comb begin
    state_d = state_q;
    timer_d = expired ? '0 : DW'(timer_q - DW'(1));
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (start) begin
          state_d = NS_GREEN;
          timer_d = load_val(green_q);
        end
      end
      NS_GREEN, EW_GREEN: begin
        if (emerg_w) begin
          state_d = (state_q == NS_GREEN) ? ALLRED_A : ALLRED_B;
          timer_d = load_val(allred_q);
        end else if (expired && (((state_q == NS_GREEN) ? ew_req : ns_req) || !start)) begin
          state_d = (state_q == NS_GREEN) ? NS_YELLOW : EW_YELLOW;
          timer_d = load_val(yellow_q);
        end
      end
      NS_YELLOW, EW_YELLOW: begin
        if (emerg_w || expired) begin
          state_d = (state_q == NS_YELLOW) ? ALLRED_A : ALLRED_B;
          timer_d = load_val(allred_q);
        end
      end
      ALLRED_A, ALLRED_B: begin
        if (emerg_w) begin
          timer_d = load_val(allred_q);
        end else if (expired) begin
          if (start) begin
            state_d = (state_q == ALLRED_A) ? EW_GREEN : NS_GREEN;
            timer_d = load_val(green_q);
          end else begin
            state_d = IDLE;
            timer_d = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  // Lamp decode straight from the state register
  always_comb begin
    ns_red    = 1'b1;
    ns_yellow = 1'b0;
    ns_green  = 1'b0;
    ew_red    = 1'b1;
    ew_yellow = 1'b0;
    ew_green  = 1'b0;
    case (state_q)
      NS_GREEN:  begin ns_red = 1'b0; ns_green  = 1'b1; end
      NS_YELLOW: begin ns_red = 1'b0; ns_yellow = 1'b1; end
      EW_GREEN:  begin ew_red = 1'b0; ew_green  = 1'b1; end
      EW_YELLOW: begin ew_red = 1'b0; ew_yellow = 1'b1; end
      default:   ;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    case (addr)
      2'd0:    rd_mux = {status_b3, state_q};
      2'd1:    rd_mux = green_q;
      2'd2:    rd_mux = yellow_q;
      default: rd_mux = allred_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state_q <= IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Register bank and read port
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      green_q   <= DW'(GREEN_RST);
      yellow_q  <= DW'(YELLOW_RST);
      allred_q  <= DW'(ALLRED_RST);
      rd_data_q <= '0;
    end else if (cs) begin
      if (write) begin
        case (addr)
          2'd1:    green_q  <= wr_data;
          2'd2:    yellow_q <= wr_data;
          2'd3:    allred_q <= wr_data;
          default: ;
        endcase
      end else begin
        rd_data_q <= rd_mux;
      end
    end
  end

endmodule

// File: tb/tb_tl_intersection_sched.sv
// Self-checking bench for tl_intersection_sched: vector table, corner sequences, random vs. phase model.
module tb_tl_intersection_sched;

  localparam logic [5:0] L_ALLR = 6'b100_100;
  localparam logic [5:0] L_NSG  = 6'b001_100;
  localparam logic [5:0] L_NSY  = 6'b010_100;
  localparam logic [5:0] L_EWG  = 6'b100_001;
  localparam logic [5:0] L_EWY  = 6'b100_010;

  logic       clk;
  logic       reset_b, start, cs, write, ns_req, ew_req;
  logic [1:0] addr;
  logic [3:0] wr_data, rd_data;
  logic       ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, busy;
`ifdef TL_EMERGENCY_EN
  logic       emerg;
`endif

  tl_intersection_sched dut (
    .clk(clk), .reset_b(reset_b), .start(start), .cs(cs), .write(write),
    .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
    .ns_req(ns_req), .ew_req(ew_req),
`ifdef TL_EMERGENCY_EN
    .emerg(emerg),
`endif
    .ns_red(ns_red), .ns_yellow(ns_yellow), .ns_green(ns_green),
    .ew_red(ew_red), .ew_yellow(ew_yellow), .ew_green(ew_green),
    .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h at %0t", name, idx, act, exp, $time);
    end
  endtask

  // Reference model: phase number, cycles spent in phase, and dwell length locked at entry
  int         m_phase, m_elapsed, m_len;
  logic [3:0] m_reg [4];
  logic [3:0] m_rd;
  int         cyc = 0;

  function automatic int dwell(input logic [3:0] r);
    return (r == 4'd0) ? 1 : int'(r);
  endfunction

  function automatic logic [5:0] lamps_of(input int p);
    case (p)
      1:       return L_NSG;
      2:       return L_NSY;
      4:       return L_EWG;
      5:       return L_EWY;
      default: return L_ALLR;
    endcase
  endfunction

  function automatic int reg_for(input int p);
    case (p)
      1, 4:    return 1;
      2, 5:    return 2;
      default: return 3;
    endcase
  endfunction

  task automatic model_update();
    int  np;
    bit  done, em, hold_em;
    logic b3;
    if (!reset_b) begin
      m_phase = 0; m_elapsed = 0; m_len = 0; m_rd = 4'd0;
      m_reg[0] = 4'd0; m_reg[1] = 4'd5; m_reg[2] = 4'd2; m_reg[3] = 4'd1;
      return;
    end
`ifdef TL_EMERGENCY_EN
    em = emerg;
    b3 = emerg;
`else
    em = 1'b0;
    b3 = (m_phase != 0);
`endif
    done    = (m_elapsed >= m_len);
    np      = m_phase;
    hold_em = 1'b0;
    if (cs && !write) m_rd = (addr == 2'd0) ? {b3, 3'(m_phase)} : m_reg[addr];
    case (m_phase)
      0: if (start) np = 1;
      1, 4: begin
        if (em) np = (m_phase == 1) ? 3 : 6;
        else if (done && (((m_phase == 1) ? ew_req : ns_req) || !start)) np = m_phase + 1;
      end
      2, 5: if (em || done) np = m_phase + 1;
      default: begin
        if (em) hold_em = 1'b1;
        else if (done) np = start ? ((m_phase == 3) ? 4 : 1) : 0;
      end
    endcase
    if (np != m_phase) begin
      m_phase   = np;
      m_elapsed = 1;
      m_len     = (np == 0) ? 0 : dwell(m_reg[reg_for(np)]);
    end else if (hold_em) begin
      m_elapsed = 1;
      m_len     = dwell(m_reg[3]);
    end else begin
      m_elapsed++;
    end
    if (cs && write && addr != 2'd0) m_reg[addr] = wr_data;
  endtask

  // One clock: advance model with the applied inputs, then compare after the edge
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    cyc++;
    chk("model_lamps", cyc, 32'({ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green}), 32'(lamps_of(m_phase)));
    chk("model_busy", cyc, 32'(busy), 32'(m_phase != 0));
    chk("model_rd", cyc, 32'(rd_data), 32'(m_rd));
  endtask

  task automatic expect_n(input string name, input logic [5:0] lamps, input logic bz, input int n);
    for (int k = 0; k < n; k++) begin
      step();
      chk(name, k, 32'({ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green}), 32'(lamps));
      chk({name, "_busy"}, k, 32'(busy), 32'(bz));
    end
  endtask

  typedef struct {
    logic       rst_n, st, c, w;
    logic [1:0] a;
    logic [3:0] wd;
    logic       nr, er;
    logic [5:0] lamps;
    logic       bz;
    logic [3:0] rd;
  } vec_t;

  vec_t tbl [26];

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0,  1'b0, 1'b0, L_ALLR, 1'b0, 4'd0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 4'd0,  1'b0, 1'b0, L_ALLR, 1'b0, 4'd5};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 4'd0,  1'b0, 1'b0, L_ALLR, 1'b0, 4'd2};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 4'd0,  1'b0, 1'b0, L_ALLR, 1'b0, 4'd1};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 4'd0,  1'b0, 1'b0, L_ALLR, 1'b0, 4'd0};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 4'd3,  1'b0, 1'b0, L_ALLR, 1'b0, 4'd0};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 4'd2,  1'b0, 1'b0, L_ALLR, 1'b0, 4'd0};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 2'd3, 4'd1,  1'b0, 1'b0, L_ALLR, 1'b0, 4'd0};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0,  1'b0, 1'b1, L_NSG,  1'b1, 4'd0};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0,  1'b0, 1'b1, L_NSG,  1'b1, 4'd0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0,  1'b0, 1'b1, L_NSG,  1'b1, 4'd0};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0,  1'b0, 1'b1, L_NSY,  1'b1, 4'd0};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0,  1'b0, 1'b1, L_NSY,  1'b1, 4'd0};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0,  1'b0, 1'b1, L_ALLR, 1'b1, 4'd0};
    tbl[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0,  1'b0, 1'b1, L_EWG,  1'b1, 4'd0};
    tbl[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0,  1'b0, 1'b1, L_EWG,  1'b1, 4'd0};
    tbl[16] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0,  1'b0, 1'b1, L_EWG,  1'b1, 4'd0};
    tbl[17] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0,  1'b0, 1'b1, L_EWG,  1'b1, 4'd0};
    tbl[18] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0,  1'b1, 1'b1, L_EWY,  1'b1, 4'd0};
    tbl[19] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0,  1'b0, 1'b1, L_EWY,  1'b1, 4'd0};
    tbl[20] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0,  1'b0, 1'b1, L_ALLR, 1'b1, 4'd0};
    tbl[21] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0,  1'b0, 1'b1, L_ALLR, 1'b0, 4'd0};
    tbl[22] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 4'd0,  1'b0, 1'b0, L_ALLR, 1'b0, 4'd0};
    tbl[23] = '{1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 4'hF,  1'b0, 1'b0, L_ALLR, 1'b0, 4'd0};
    tbl[24] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 4'd0,  1'b0, 1'b0, L_ALLR, 1'b0, 4'd0};
    tbl[25] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 4'd0,  1'b0, 1'b0, L_ALLR, 1'b0, 4'd3};

    reset_b = 1'b0; start = 1'b0; cs = 1'b0; write = 1'b0; addr = 2'd0;
    wr_data = 4'd0; ns_req = 1'b0; ew_req = 1'b0;
`ifdef TL_EMERGENCY_EN
    emerg = 1'b0;
`endif

    // Vector table: reset, register readback, programmed cycle, start drop, status writes
    for (int i = 0; i < 26; i++) begin
      reset_b = tbl[i].rst_n; start = tbl[i].st; cs = tbl[i].c; write = tbl[i].w;
      addr = tbl[i].a; wr_data = tbl[i].wd; ns_req = tbl[i].nr; ew_req = tbl[i].er;
      step();
      chk("vec_lamps", i, 32'({ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green}), 32'(tbl[i].lamps));
      chk("vec_busy", i, 32'(busy), 32'(tbl[i].bz));
      chk("vec_rd", i, 32'(rd_data), 32'(tbl[i].rd));
    end

    // Green extension with no requests, then ew_req ends it
    cs = 1'b0; start = 1'b1; ns_req = 1'b0; ew_req = 1'b0;
    expect_n("ext_green", L_NSG, 1'b1, 15);
    ew_req = 1'b1;
    expect_n("ext_yellow", L_NSY, 1'b1, 1);
    ew_req = 1'b0; start = 1'b0;
    expect_n("ext_y2", L_NSY, 1'b1, 1);
    expect_n("ext_ar", L_ALLR, 1'b1, 1);
    expect_n("ext_idle", L_ALLR, 1'b0, 1);

    // Green dwell register of 0 gives a single green cycle
    cs = 1'b1; write = 1'b1; addr = 2'd1; wr_data = 4'd0;
    step();
    cs = 1'b0; write = 1'b0; start = 1'b1; ew_req = 1'b1;
    expect_n("g0_green", L_NSG, 1'b1, 1);
    expect_n("g0_yellow", L_NSY, 1'b1, 1);
    start = 1'b0;
    expect_n("g0_y2", L_NSY, 1'b1, 1);
    expect_n("g0_ar", L_ALLR, 1'b1, 1);
    expect_n("g0_idle", L_ALLR, 1'b0, 1);

    // Reset reloads defaults; start dropped during EW green completes every phase
    reset_b = 1'b0;
    step();
    reset_b = 1'b1; start = 1'b1; ew_req = 1'b1; ns_req = 1'b0;
    expect_n("drop_nsg", L_NSG, 1'b1, 5);
    expect_n("drop_nsy", L_NSY, 1'b1, 2);
    expect_n("drop_ara", L_ALLR, 1'b1, 1);
    expect_n("drop_ewg0", L_EWG, 1'b1, 1);
    start = 1'b0;
    expect_n("drop_ewg", L_EWG, 1'b1, 4);
    expect_n("drop_ewy", L_EWY, 1'b1, 2);
    expect_n("drop_arb", L_ALLR, 1'b1, 1);
    expect_n("drop_idle", L_ALLR, 1'b0, 1);
    cs = 1'b1; write = 1'b0; addr = 2'd0;
    step();
    chk("drop_status", 0, 32'(rd_data), 32'd0);
    cs = 1'b0;

`ifdef TL_EMERGENCY_EN
    // Emergency pulse during NS green forces all-red, then one all-red cycle and EW green
    start = 1'b1; ew_req = 1'b1;
    expect_n("em_nsg", L_NSG, 1'b1, 2);
    emerg = 1'b1;
    expect_n("em_ar", L_ALLR, 1'b1, 1);
    emerg = 1'b0;
    expect_n("em_ewg", L_EWG, 1'b1, 1);
    start = 1'b0;
    for (int k = 0; k < 12; k++) step();
`endif

    // Randomised traffic, bus and reset activity checked against the model
    for (int n = 0; n < 4000; n++) begin
      reset_b = ($urandom_range(0, 299) != 0);
      start   = ($urandom_range(0, 15) != 0);
      ns_req  = ($urandom_range(0, 3) == 0);
      ew_req  = ($urandom_range(0, 3) == 0);
      cs      = ($urandom_range(0, 3) == 0);
      write   = $urandom_range(0, 1) == 1;
      addr    = 2'($urandom_range(0, 3));
      wr_data = 4'($urandom_range(0, 4));
`ifdef TL_EMERGENCY_EN
      emerg   = ($urandom_range(0, 24) == 0);
`endif
      step();
      chk("rnd_one_green", n, 32'(ns_green & ew_green), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
